// File: rtl/flit_activity_monitor.sv
// Frames a 60-bit flit stream into packets and reports per-packet length and
// bus switching activity (Hamming distance between consecutive flits).
module flit_activity_monitor #(
    parameter int N       = 30,
    parameter int PAYLOAD = 20,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flit_valid,
    input  logic [2*N-1:0]   flit_data,
    output logic             pkt_done,
    output logic [CNT_W-1:0] pkt_toggles,
    output logic [7:0]       pkt_len,
    output logic             pkt_err,
    output logic [CNT_W-1:0] pkt_count,
    output logic [N-1:0]     op1_q,
    output logic [N-1:0]     op2_q
);

    // Handshake: no ready; every cycle with flit_valid=1 transfers exactly one
    // flit, and pkt_done is a single-cycle strobe qualifying the pkt_* outputs.
    localparam int D_W = $clog2(2*N+1);
    localparam logic [7:0] PAYLOAD_L = 8'(PAYLOAD);

    typedef enum logic {IDLE, RECV} state_t;

    state_t           state_q, state_d;
    logic [2*N-1:0]   prev_q, prev_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [7:0]       len_q, len_d;
    logic             pkt_done_q, pkt_done_d;
    logic [CNT_W-1:0] pkt_toggles_q, pkt_toggles_d;
    logic [7:0]       pkt_len_q, pkt_len_d;
    logic             pkt_err_q, pkt_err_d;
    logic [CNT_W-1:0] pkt_count_q, pkt_count_d;
    logic [N-1:0]     op1_d, op2_d;

    logic [2*N-1:0]   flit_xor;
    logic [D_W-1:0]   d_cnt;
    logic [CNT_W-1:0] acc_plus;
    logic [CNT_W-1:0] first_acc;
    logic [7:0]       len_inc;
    logic             close_en;
    logic [CNT_W-1:0] close_tog;
    logic [7:0]       close_len;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [D_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W+1)'(b);
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    always_comb begin
        flit_xor = flit_data ^ prev_q;
        d_cnt    = '0;
        for (int i = 0; i < 2*N; i++) begin
            d_cnt = d_cnt + D_W'(flit_xor[i]);
        end
        acc_plus  = sat_add(acc_q, d_cnt);
        first_acc = sat_add('0, d_cnt);
        len_inc   = (len_q == 8'hFF) ? 8'hFF : len_q + 8'd1;
    end

    always_comb begin
        state_d       = state_q;
        prev_d        = prev_q;
        acc_d         = acc_q;
        len_d         = len_q;
        op1_d         = op1_q;
        op2_d         = op2_q;
        pkt_done_d    = 1'b0;
        pkt_toggles_d = pkt_toggles_q;
        pkt_len_d     = pkt_len_q;
        pkt_err_d     = pkt_err_q;
        pkt_count_d   = pkt_count_q;
        close_en      = 1'b0;
        close_tog     = '0;
        close_len     = '0;

        if (flit_valid) begin
            prev_d = flit_data;
            op1_d  = flit_data[N-1:0];
            op2_d  = flit_data[2*N-1:N];
        end

        case (state_q)
            IDLE: begin
                if (flit_valid) begin
                    if (PAYLOAD_L == 8'd1) begin
                        close_en  = 1'b1;
                        close_tog = first_acc;
                        close_len = 8'd1;
                    end else begin
                        state_d = RECV;
                        acc_d   = first_acc;
                        len_d   = 8'd1;
                    end
                end
            end
            RECV: begin
                if (flit_valid) begin
                    if (len_inc == PAYLOAD_L) begin
                        close_en  = 1'b1;
                        close_tog = acc_plus;
                        close_len = len_inc;
                    end else begin
                        acc_d = acc_plus;
                        len_d = len_inc;
                    end
                end else begin
                    close_en  = 1'b1;
                    close_tog = acc_q;
                    close_len = len_q;
                end
            end
            default: state_d = IDLE;
        endcase

        if (close_en) begin
            pkt_toggles_d = close_tog;
            pkt_len_d     = close_len;
            pkt_err_d     = (close_len != PAYLOAD_L);
            pkt_count_d   = pkt_count_q + 1'b1;
            pkt_done_d    = 1'b1;
            acc_d         = '0;
            len_d         = '0;
            state_d       = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            prev_q        <= '0;
            acc_q         <= '0;
            len_q         <= '0;
            op1_q         <= '0;
            op2_q         <= '0;
            pkt_done_q    <= 1'b0;
            pkt_toggles_q <= '0;
            pkt_len_q     <= '0;
            pkt_err_q     <= 1'b0;
            pkt_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            prev_q        <= prev_d;
            acc_q         <= acc_d;
            len_q         <= len_d;
            op1_q         <= op1_d;
            op2_q         <= op2_d;
            pkt_done_q    <= pkt_done_d;
            pkt_toggles_q <= pkt_toggles_d;
            pkt_len_q     <= pkt_len_d;
            pkt_err_q     <= pkt_err_d;
            pkt_count_q   <= pkt_count_d;
        end
    end

    assign pkt_done    = pkt_done_q;
    assign pkt_toggles = pkt_toggles_q;
    assign pkt_len     = pkt_len_q;
    assign pkt_err     = pkt_err_q;
    assign pkt_count   = pkt_count_q;

endmodule

// File: tb/tb_flit_activity_monitor.sv
// Directed bench for flit_activity_monitor: a per-packet vector table plus
// hand-written back-to-back, injector-traffic and mid-packet reset sequences.
module tb_flit_activity_monitor;

    localparam int N     = 30;
    localparam int PL    = 20;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             flit_valid;
    logic [2*N-1:0]   flit_data;
    logic             pkt_done;
    logic [CNT_W-1:0] pkt_toggles;
    logic [7:0]       pkt_len;
    logic             pkt_err;
    logic [CNT_W-1:0] pkt_count;
    logic [N-1:0]     op1_q;
    logic [N-1:0]     op2_q;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [2*N-1:0] ONES  = {(2*N){1'b1}};
    localparam logic [2*N-1:0] ZEROS = '0;
    localparam logic [2*N-1:0] LOW16 = 60'h00000000000FFFF;

    flit_activity_monitor #(.N(N), .PAYLOAD(PL), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flit_valid(flit_valid), .flit_data(flit_data),
        .pkt_done(pkt_done), .pkt_toggles(pkt_toggles), .pkt_len(pkt_len),
        .pkt_err(pkt_err), .pkt_count(pkt_count), .op1_q(op1_q), .op2_q(op2_q)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Drivers: inputs change 1 time unit after the rising edge, outputs are
    // sampled at that same point.
    task automatic do_reset();
        rst        = 1'b1;
        flit_valid = 1'b0;
        flit_data  = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic send_flit(input logic [2*N-1:0] f);
        flit_valid = 1'b1;
        flit_data  = f;
        @(posedge clk); #1;
        flit_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        flit_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_report(input string tag, input logic [CNT_W-1:0] tog,
                                input logic [7:0] len, input logic err,
                                input logic [CNT_W-1:0] cnt);
        check({tag, ".done"}, 64'(pkt_done), 64'd1);
        check({tag, ".toggles"}, 64'(pkt_toggles), 64'(tog));
        check({tag, ".len"}, 64'(pkt_len), 64'(len));
        check({tag, ".err"}, 64'(pkt_err), 64'(err));
        check({tag, ".count"}, 64'(pkt_count), 64'(cnt));
    endtask

    typedef struct {
        int               n;
        logic [2*N-1:0]   a;     // odd-position flits (1st, 3rd, ...)
        logic [2*N-1:0]   b;     // even-position flits
        logic [CNT_W-1:0] exp_tog;
        logic [7:0]       exp_len;
        logic             exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [2*N-1:0]   last;
        logic [2*N-1:0]   prev_m;
        logic [2*N-1:0]   f;
        logic [CNT_W-1:0] tog_m;
        logic [CNT_W-1:0] cnt_m;

        // Each row runs from reset, so prev starts at zero.
        vecs[0] = '{PL, ONES,  ONES,  16'd60,   8'd20, 1'b0};
        vecs[1] = '{PL, ONES,  ZEROS, 16'd1200, 8'd20, 1'b0};
        vecs[2] = '{5,  LOW16, LOW16, 16'd16,   8'd5,  1'b1};
        vecs[3] = '{1,  ONES,  ONES,  16'd60,   8'd1,  1'b1};
        vecs[4] = '{19, ONES,  ZEROS, 16'd1140, 8'd19, 1'b1};
        vecs[5] = '{PL, ZEROS, ZEROS, 16'd0,    8'd20, 1'b0};

        do_reset();
        check("reset.done", 64'(pkt_done), 64'd0);
        check("reset.toggles", 64'(pkt_toggles), 64'd0);
        check("reset.len", 64'(pkt_len), 64'd0);
        check("reset.err", 64'(pkt_err), 64'd0);
        check("reset.count", 64'(pkt_count), 64'd0);
        check("reset.op1", 64'(op1_q), 64'd0);
        check("reset.op2", 64'(op2_q), 64'd0);

        for (int v = 0; v < 6; v++) begin
            do_reset();
            last = '0;
            for (int i = 0; i < vecs[v].n; i++) begin
                last = (i % 2 == 0) ? vecs[v].a : vecs[v].b;
                send_flit(last);
                if (i == vecs[v].n - 2)
                    check($sformatf("vec%0d.no_early_done", v), 64'(pkt_done), 64'd0);
            end
            check($sformatf("vec%0d.op1", v), 64'(op1_q), 64'(last[N-1:0]));
            check($sformatf("vec%0d.op2", v), 64'(op2_q), 64'(last[2*N-1:N]));
            if (vecs[v].n < PL) begin
                check($sformatf("vec%0d.short_no_done", v), 64'(pkt_done), 64'd0);
                idle_cycle();
            end
            check_report($sformatf("vec%0d", v), vecs[v].exp_tog, vecs[v].exp_len,
                         vecs[v].exp_err, 16'd1);
            idle_cycle();
            check($sformatf("vec%0d.pulse_end", v), 64'(pkt_done), 64'd0);
            check($sformatf("vec%0d.hold_tog", v), 64'(pkt_toggles), 64'(vecs[v].exp_tog));
        end

        // Back-to-back: zeros packet then ones packet with no gap.
        do_reset();
        for (int i = 0; i < PL; i++) send_flit(ZEROS);
        check_report("b2b_a", 16'd0, 8'd20, 1'b0, 16'd1);
        for (int i = 0; i < PL; i++) begin
            send_flit(ONES);
            if (i == 0) check("b2b.gap_low", 64'(pkt_done), 64'd0);
        end
        check_report("b2b_b", 16'd60, 8'd20, 1'b0, 16'd2);

        // Injector-like traffic: 10 random packets, 7 idle cycles between.
        do_reset();
        prev_m = '0;
        cnt_m  = '0;
        for (int p = 0; p < 10; p++) begin
            tog_m = '0;
            for (int i = 0; i < PL; i++) begin
                f = {N'($urandom_range(0, 32'h3FFF_FFFF)), N'($urandom_range(0, 32'h3FFF_FFFF))};
                tog_m  = tog_m + CNT_W'($countones(f ^ prev_m));
                prev_m = f;
                send_flit(f);
            end
            cnt_m = cnt_m + 1'b1;
            check_report($sformatf("inj%0d", p), tog_m, 8'd20, 1'b0, cnt_m);
            for (int g = 0; g < 7; g++) begin
                idle_cycle();
                if (g == 0) check($sformatf("inj%0d.pulse_end", p), 64'(pkt_done), 64'd0);
            end
        end

        // Mid-packet reset: prev is ones when reset hits, so a stale prev
        // would make the following all-ones packet report 0.
        do_reset();
        for (int i = 0; i < PL; i++) send_flit(LOW16);
        check_report("pre_rst", 16'd16, 8'd20, 1'b0, 16'd1);
        for (int i = 0; i < 12; i++) send_flit(ONES);
        do_reset();
        check("midrst.done", 64'(pkt_done), 64'd0);
        check("midrst.toggles", 64'(pkt_toggles), 64'd0);
        check("midrst.len", 64'(pkt_len), 64'd0);
        check("midrst.count", 64'(pkt_count), 64'd0);
        check("midrst.op1", 64'(op1_q), 64'd0);
        check("midrst.op2", 64'(op2_q), 64'd0);
        idle_cycle();
        check("midrst.no_done", 64'(pkt_done), 64'd0);
        for (int i = 0; i < PL; i++) send_flit(ONES);
        check_report("post_rst", 16'd60, 8'd20, 1'b0, 16'd1);
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
